// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the Select line of a shared-resource mux.
// Grants one requester at a time, holds until release, and preempts long holders.
module mux_rr_arbiter #(
    parameter int nREQ     = 4,
    parameter int bSEL     = 2,
    parameter int MAX_HOLD = 16,
    parameter int bCNT     = 5
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic [nREQ-1:0] Request,
    output logic [nREQ-1:0] Grant,
    output logic [bSEL-1:0] Select,
    output logic            Busy,
    output logic            Preempt
);

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_e;

    localparam logic [bCNT-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : bCNT'(MAX_HOLD - 1);
    localparam logic [bSEL-1:0] LAST_INIT = bSEL'(nREQ - 1);

    state_e          state_q, state_d;
    logic [nREQ-1:0] grant_q, grant_d;
    logic [bSEL-1:0] select_q, select_d;
    logic            busy_q, busy_d;
    logic            preempt_q, preempt_d;
    logic [bCNT-1:0] hold_cnt_q, hold_cnt_d;
    logic [bSEL-1:0] last_q, last_d;

    logic [bSEL-1:0] win;
    logic [bSEL-1:0] cand;
    logic            found;
    logic            others_waiting;

    // Round-robin pick: first set request bit after the last owner, wrapping mod nREQ.
    always_comb begin
        win   = last_q;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= nREQ; k++) begin
            cand = bSEL'((int'(last_q) + k) % nREQ);
            if (!found && Request[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // grant_q is the owner's one-hot while GRANTED, so masking it leaves the waiters.
    assign others_waiting = |(Request & ~grant_q);

    always_comb begin
        // NOTE: every _d gets a default before any branch so no latch is inferred.
        state_d    = state_q;
        grant_d    = grant_q;
        select_d   = select_q;
        busy_d     = busy_q;
        preempt_d  = 1'b0;
        hold_cnt_d = hold_cnt_q;
        last_d     = last_q;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d      = GRANTED;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    select_d     = win;
                    busy_d       = 1'b1;
                    last_d       = win;
                    hold_cnt_d   = '0;
                end
            end
            GRANTED: begin
                if (!Request[select_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end else if ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST) && others_waiting) begin
                    // Last stays on the revoked owner so it ranks lowest next time.
                    state_d   = IDLE;
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    preempt_d = 1'b1;
                end else if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + bCNT'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            select_q   <= '0;
            busy_q     <= 1'b0;
            preempt_q  <= 1'b0;
            hold_cnt_q <= '0;
            last_q     <= LAST_INIT;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            select_q   <= select_d;
            busy_q     <= busy_d;
            preempt_q  <= preempt_d;
            hold_cnt_q <= hold_cnt_d;
            last_q     <= last_d;
        end
    end

    assign Grant   = grant_q;
    assign Select  = select_q;
    assign Busy    = busy_q;
    assign Preempt = preempt_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter (nREQ=4, MAX_HOLD=16).
// Inputs change 1 time unit after the rising edge; outputs are read at the same point.
module tb_mux_rr_arbiter;

    localparam int NREQ = 4;
    localparam int BSEL = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [NREQ-1:0] request = '0;
    logic [NREQ-1:0] grant;
    logic [BSEL-1:0] select;
    logic            busy;
    logic            preempt;

    int n_cmp = 0;
    int n_err = 0;

    mux_rr_arbiter #(
        .nREQ    (NREQ),
        .bSEL    (BSEL),
        .MAX_HOLD(16),
        .bCNT    (5)
    ) dut (
        .Clk    (clk),
        .Reset_n(rst_n),
        .Request(request),
        .Grant  (grant),
        .Select (select),
        .Busy   (busy),
        .Preempt(preempt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        request = '0;
        rst_n   = 1'b0;
        #2;
        rst_n   = 1'b1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                              input logic b, input logic p);
        check({tag, ".grant"},   32'(grant),   32'(g));
        check({tag, ".select"},  32'(select),  32'(s));
        check({tag, ".busy"},    32'(busy),    32'(b));
        check({tag, ".preempt"}, 32'(preempt), 32'(p));
    endtask

    // Structural invariants checked mid-cycle whenever out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            check("inv.onehot0", 32'($onehot0(grant)), 32'd1);
            check("inv.busy_eq_grant", 32'(busy), 32'(|grant));
            if (busy) check("inv.select_matches", 32'(grant), 32'(4'b0001 << select));
        end
    end

    initial begin
        logic [1:0] order [5];
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        // 1: reset with all requests asserted, then first grant to requester 0
        request = 4'b1111;
        #1 rst_n = 1'b0;
        #2;
        expect_out("t1.rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        tick();
        expect_out("t1.rst_held", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        expect_out("t1.first", 4'b0001, 2'd0, 1'b1, 1'b0);
        request = 4'b0000;
        tick();
        expect_out("t1.release", 4'b0000, 2'd0, 1'b0, 1'b0);

        // 2: single requester 2 held 3 cycles, Select stays 2 while idle
        request = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            tick();
            expect_out("t2.hold", 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        request = 4'b0000;
        tick();
        expect_out("t2.idle", 4'b0000, 2'd2, 1'b0, 1'b0);
        tick();
        expect_out("t2.idle2", 4'b0000, 2'd2, 1'b0, 1'b0);

        // 3: rotation 0,1,2,3,0 with one idle cycle between owners
        do_reset();
        request = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            expect_out("t3.own", 4'b0001 << order[i], order[i], 1'b1, 1'b0);
            tick();
            expect_out("t3.own2", 4'b0001 << order[i], order[i], 1'b1, 1'b0);
            request = 4'b1111 & ~(4'b0001 << order[i]);
            tick();
            expect_out("t3.gap", 4'b0000, order[i], 1'b0, 1'b0);
            request = 4'b1111;
            tick();
        end
        expect_out("t3.next", 4'b0010, 2'd1, 1'b1, 1'b0);
        request = 4'b0000;
        tick();

        // 4: preemption after 16 held cycles, then requester 1 wins
        do_reset();
        request = 4'b0011;
        for (int c = 0; c < 16; c++) begin
            tick();
            expect_out("t4.hold", 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        tick();
        expect_out("t4.preempt", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick();
        expect_out("t4.regrant", 4'b0010, 2'd1, 1'b1, 1'b0);
        request = 4'b0000;
        tick();
        expect_out("t4.release", 4'b0000, 2'd1, 1'b0, 1'b0);

        // 5: lone requester never preempted
        do_reset();
        request = 4'b0001;
        for (int c = 0; c < 40; c++) begin
            tick();
            expect_out("t5.lone", 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        request = 4'b0000;
        tick();

        // Release coinciding with preemption condition is a normal release
        do_reset();
        request = 4'b0011;
        for (int c = 0; c < 16; c++) tick();
        expect_out("t7.last_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
        request = 4'b0010;
        tick();
        expect_out("t7.release_no_preempt", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        expect_out("t7.regrant", 4'b0010, 2'd1, 1'b1, 1'b0);
        request = 4'b0000;
        tick();

        // 6: asynchronous reset mid-grant clears history
        request = 4'b0100;
        tick();
        expect_out("t6.owner2", 4'b0100, 2'd2, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        expect_out("t6.async", 4'b0000, 2'd0, 1'b0, 1'b0);
        request = 4'b1111;
        #1 rst_n = 1'b1;
        tick();
        expect_out("t6.after", 4'b0001, 2'd0, 1'b1, 1'b0);
        request = 4'b0000;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
